q_seq_monitor: RTL

Downstream checker for the 4-bit sequence output Q of the counter stage (`top`). On every enabled clock it samples the value and checks that it advances by +1 modulo 2^WIDTH. It acquires lock after a run of correct steps and flags skips, stalls and wrap-arounds. It also keeps a saturating error count for bench and on-board self-check use.

---
 rtl/q_seq_pkg.sv | 17 +
 rtl/q_seq_monitor_sat_counter.sv | 35 +++
 rtl/q_seq_monitor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/q_seq_pkg.sv
// Shared types and default constants for the Q sequence monitor.
package q_seq_pkg;

   localparam int unsigned WIDTH_DEF    = 4;
   localparam int unsigned LOCK_CNT_DEF = 3;
   localparam int unsigned ERR_W_DEF    = 8;
   localparam int unsigned STREAK_W     = 4;

   // Tracking state: ACQ captures the first value, LOCK counts correct
   // steps, TRACK is the locked, error-reporting state.
   typedef enum logic [1:0] {
      ACQ   = 2'd0,
      LOCK  = 2'd1,
      TRACK = 2'd2
   } state_e;

endpackage

// File: rtl/q_seq_monitor_sat_counter.sv
// Saturating up-counter: counts INC pulses and sticks at all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         INC,
   output logic [W-1:0] CNT
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: increment only while below the saturation value.
   always_comb begin
      cnt_d = cnt_q;
      if (INC && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign CNT = cnt_q;

endmodule

// File: rtl/q_seq_monitor.sv
// Sequence monitor for the counter stage output. Checks that each enabled
// sample is the previous one plus 1 (mod 2^WIDTH), locks after LOCK_CNT
// correct steps, and reports ERR/WRAP pulses plus a saturating error count.
// Optional: define Q_SEQ_MONITOR_WRAP_CNT_EN to add the WRAP_CNT output.
module q_seq_monitor
   import q_seq_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
   parameter int unsigned ERR_W    = ERR_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] Q_IN,
   input  logic             EN,
   output logic             LOCKED,
   output logic             ERR,
   output logic             WRAP,
   output logic [ERR_W-1:0] ERR_CNT
`ifdef Q_SEQ_MONITOR_WRAP_CNT_EN
   ,
   output logic [ERR_W-1:0] WRAP_CNT
`endif
);

   localparam logic [STREAK_W-1:0] LOCK_CNT_C = STREAK_W'(LOCK_CNT);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    ref_q, ref_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                locked_q, locked_d;
   logic                err_q, err_d;
   logic                wrap_q, wrap_d;

   logic [WIDTH-1:0]    exp_s;
   logic                match_s;
   logic                ref_ones_s;
   logic [STREAK_W-1:0] streak_inc_s;

   assign exp_s        = ref_q + WIDTH'(1'b1);
   assign match_s      = (Q_IN == exp_s);
   assign ref_ones_s   = (ref_q == {WIDTH{1'b1}});
   assign streak_inc_s = streak_q + STREAK_W'(1'b1);

   // Next-state and pulse decisions; with EN low everything holds and the
   // pulses drop to zero.
   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      streak_d = streak_q;
      err_d    = 1'b0;
      wrap_d   = 1'b0;
      if (EN) begin
         case (state_q)
            ACQ: begin
               ref_d    = Q_IN;
               streak_d = {STREAK_W{1'b0}};
               state_d  = LOCK;
            end
            LOCK: begin
               ref_d = Q_IN;
               if (match_s) begin
                  streak_d = streak_inc_s;
                  if (streak_inc_s == LOCK_CNT_C) begin
                     state_d = TRACK;
                  end else begin
                     state_d = LOCK;
                  end
               end else begin
                  streak_d = {STREAK_W{1'b0}};
                  state_d  = LOCK;
               end
            end
            TRACK: begin
               ref_d = Q_IN;
               if (match_s) begin
                  wrap_d  = ref_ones_s;
                  state_d = TRACK;
               end else begin
                  // Any non-increment, stall included, drops lock and
                  // re-anchors on the new value.
                  err_d    = 1'b1;
                  streak_d = {STREAK_W{1'b0}};
                  state_d  = LOCK;
               end
            end
            default: begin
               state_d  = ACQ;
               ref_d    = {WIDTH{1'b0}};
               streak_d = {STREAK_W{1'b0}};
            end
         endcase
      end else begin
         state_d  = state_q;
         ref_d    = ref_q;
         streak_d = streak_q;
      end
      locked_d = (state_d == TRACK);
   end

   // State, reference, streak and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ACQ;
         ref_q    <= {WIDTH{1'b0}};
         streak_q <= {STREAK_W{1'b0}};
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         streak_q <= streak_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         wrap_q   <= wrap_d;
      end
   end

   assign LOCKED = locked_q;
   assign ERR    = err_q;
   assign WRAP   = wrap_q;

   // Error count advances on the same edge that raises ERR.
   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .CLK (CLK),
      .RST (RST),
      .INC (err_d),
      .CNT (ERR_CNT)
   );

`ifdef Q_SEQ_MONITOR_WRAP_CNT_EN
   sat_counter #(
      .W (ERR_W)
   ) u_wrap_cnt (
      .CLK (CLK),
      .RST (RST),
      .INC (wrap_d),
      .CNT (WRAP_CNT)
   );
`else
   // Wrap pulses are reported on WRAP only; no counter is built.
`endif

endmodule
